dpram_burst_reader: RTL and testbench

- Reads a contiguous burst of 16-bit words from one port of the team's dual-port RAM (8-bit address, 16-bit data, synchronous read).
- Presents the words as a valid/ready stream, with a last-beat marker and a done pulse.
- Sits on the read side of the DPRAM; the other port is used by the producer that writes the buffer.
- Tolerates one-cycle RAM read latency and arbitrary consumer backpressure without losing or duplicating words.

---
 rtl/dpram_burst_reader.sv | 141 ++++++++++++++
 tb/tb_dpram_burst_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : dpram_burst_reader
// Brief    : Streams a contiguous burst of words out of the DPRAM read port
//            as a valid/ready stream with last-beat tag and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_burst_reader #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [AW:0] c_ZERO = '0;
    localparam logic [AW:0] c_ONE  = {{AW{1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [AW-1:0] r_base;
    logic [AW:0]   r_length;
    logic [AW:0]   r_issued;
    logic          r_inflight;
    logic          r_inflight_last;

    logic [DW-1:0] r_mem [0:1];
    logic [1:0]    r_last;
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic [2:0]    w_cap;

    assign w_push    = r_inflight;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_mem[r_rptr];
    assign out_last  = out_valid && r_last[r_rptr];

    // Credit: buffered plus in-flight words, less the one leaving now, must stay below 2.
    assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_cap  = 3'd2 + {2'b00, w_pop};
    assign ram_en = (r_state == S_RUN) && (r_issued < r_length) && (w_occ < w_cap);

    assign ram_we   = 1'b0;
    assign ram_addr = r_base + r_issued[AW-1:0];
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_length        <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= ram_en;
            r_inflight_last <= (r_issued == r_length - c_ONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base   <= base_addr;
                        r_length <= length;
                        r_issued <= '0;
                        r_state  <= (length == c_ZERO) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (ram_en) begin
                        r_issued <= r_issued + c_ONE;
                    end
                    if (r_issued == r_length) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave as soon as the final word is accepted on this edge.
                    if (!r_inflight && (r_count == 2'd0 || (r_count == 2'd1 && w_pop))) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_last   <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr]  <= ram_rdata;
                r_last[r_wptr] <= r_inflight_last;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_burst_reader
// Brief    : Self-checking bench with a DPRAM model and a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_burst_reader;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [256];
    logic          wr_en;
    logic [7:0]    wr_addr;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Dual-port RAM: write port for the producer, synchronous read port for the DUT.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    dpram_burst_reader #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic ram_write(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic run_burst(input logic [7:0] b, input int len, input int mode, input int restart_cyc);
        logic [DW-1:0] exp_q [$];
        logic [7:0]    a;
        logic [3:0]    pat;
        logic          held;
        logic [DW-1:0] held_d;
        logic          held_l;
        int            idx;
        int            issues;
        int            accepts;
        int            last_acc;
        int            dones;
        int            budget;
        pat      = 4'b1001;
        held     = 1'b0;
        held_d   = '0;
        held_l   = 1'b0;
        idx      = 0;
        issues   = 0;
        accepts  = 0;
        last_acc = 0;
        dones    = 0;
        budget   = 4 * len + 20;
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            a = b + k[7:0];
            exp_q.push_back(mem[a]);
        end
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = len[AW:0];
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= budget && dones == 0; cyc++) begin
            @(negedge clk);
            if (cyc == restart_cyc) begin
                start     = 1'b1;
                base_addr = ~b;
                length    = 9'd7;
            end else begin
                start = 1'b0;
            end
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = pat[cyc % 4];
            else                out_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy b=%0d len=%0d cyc=%0d got=%b exp=1", b, len, cyc, busy);
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    errors++;
                    $display("FAIL stall_stable cyc=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             cyc, out_valid, out_data, out_last, held_d, held_l);
                end
            end
            held   = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_d = out_data;
            held_l = out_last;
            if (ram_en === 1'b1) begin
                a = b + issues[7:0];
                checks++;
                if (ram_addr !== a) begin
                    errors++;
                    $display("FAIL ram_addr issue=%0d got=%0d exp=%0d", issues, ram_addr, a);
                end
                issues++;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                accepts++;
                checks++;
                if (idx >= len) begin
                    errors++;
                    $display("FAIL extra_word cyc=%0d got=%h exp=none", cyc, out_data);
                end else begin
                    if (out_data !== exp_q[idx] || out_last !== 1'(idx == len - 1)) begin
                        errors++;
                        $display("FAIL word idx=%0d got d=%h l=%b exp d=%h l=%b",
                                 idx, out_data, out_last, exp_q[idx], (idx == len - 1));
                    end
                    if (mode == 0 && cyc != 3 + idx) begin
                        errors++;
                        $display("FAIL timing idx=%0d got cyc=%0d exp cyc=%0d", idx, cyc, 3 + idx);
                    end
                end
                last_acc = cyc;
                idx++;
            end
            checks++;
            if (issues - accepts > 2) begin
                errors++;
                $display("FAIL credit cyc=%0d got ahead=%0d exp<=2", cyc, issues - accepts);
            end
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (idx != len || cyc != last_acc + 1) begin
                    errors++;
                    $display("FAIL done cyc=%0d got words=%0d exp words=%0d exp cyc=%0d",
                             cyc, idx, len, last_acc + 1);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones != 1 || issues != len) begin
            errors++;
            $display("FAIL burst_end b=%0d len=%0d got dones=%0d issues=%0d exp dones=1 issues=%0d",
                     b, len, dones, issues, len);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_done got done=%b busy=%b valid=%b exp 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (ram_en !== 1'b0 || ram_addr !== 8'd0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset got en=%b addr=%0d v=%b l=%b d=%h busy=%b done=%b we=%b exp all 0",
                     ram_en, ram_addr, out_valid, out_last, out_data, busy, done, ram_we);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        ram_write(8'd0, 16'd9);
        ram_write(8'd1, 16'd10);
        ram_write(8'd2, 16'd7);
        ram_write(8'd3, 16'd7);
        run_burst(8'd0, 4, 0, 0);
    endtask

    task automatic test_backpressure;
        run_burst(8'd0, 4, 1, 0);
        run_burst(8'd0, 4, 2, 0);
    endtask

    task automatic test_wrap;
        ram_write(8'd254, 16'hAAAA);
        ram_write(8'd255, 16'hBBBB);
        ram_write(8'd0,   16'h0009);
        run_burst(8'd254, 3, 0, 0);
    endtask

    task automatic test_full;
        for (int i = 0; i < 256; i++) ram_write(i[7:0], 16'(i));
        run_burst(8'd5, 256, 0, 0);
    endtask

    task automatic test_zero_and_ignored_start;
        run_burst(8'd77, 0, 0, 0);
        run_burst(8'd40, 10, 1, 4);
    endtask

    task automatic test_reset_mid;
        int acc;
        acc = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'd10;
        length    = 9'd8;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (out_valid === 1'b1) acc++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (acc != 2 || ram_en !== 1'b0 || ram_addr !== 8'd0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || out_data !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got acc=%0d en=%b addr=%0d v=%b l=%b d=%h busy=%b done=%b exp acc=2 rest 0",
                     acc, ram_en, ram_addr, out_valid, out_last, out_data, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        run_burst(8'd100, 5, 2, 0);
    endtask

    task automatic test_random;
        logic [7:0] b;
        int         len;
        for (int n = 0; n < 6; n++) begin
            b   = 8'($urandom_range(0, 255));
            len = $urandom_range(0, 12);
            for (int k = 0; k < len; k++) ram_write(b + k[7:0], 16'($urandom));
            run_burst(b, len, 2, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_rdata = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_ignored_start();
        test_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
